// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter
//   Shares one main_memory port among three requesters:
//     0 = debug/program loader, 1 = data load/store, 2 = instruction fetch.
//   Two-state FSM (ARB -> ACCESS -> ARB): one access every two cycles,
//   round-robin winner selection, and an exclusive lock for requester 0.
//
// Handshake: a requester raises req[i] with we/addr/wdata stable. The
//   fields are captured in the ARB cycle that picks it. gnt[i] is high
//   for the single ACCESS cycle. rvalid[i] pulses for one cycle right
//   after it, for reads (rdata valid) and writes (acknowledge). req[i]
//   may drop in the rvalid cycle; if still high, it is a fresh request.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   req, we               per-requester request / write-select  [2:0]
//   addr, wdata           per-requester fields, requester i at slice i
//   lock0                 requester 0 exclusive access
//   gnt, rvalid           per-requester access / response pulses [2:0]
//   rdata                 registered read data (shared)
//   mem_raddr/waddr/wdata/wen, mem_rdata   main_memory port
//   busy                  high while in ACCESS (exposes FSM state)
//   grant_count           completed grants, requester i at slice i
module main_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                req,
    input  logic [2:0]                we,
    input  logic [3*ADDR_WIDTH-1:0]   addr,
    input  logic [3*DATA_WIDTH-1:0]   wdata,
    input  logic                      lock0,
    output logic [2:0]                gnt,
    output logic [2:0]                rvalid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [ADDR_WIDTH-1:0]     mem_raddr,
    output logic [ADDR_WIDTH-1:0]     mem_waddr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      mem_wen,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      busy,
    output logic [3*CNT_WIDTH-1:0]    grant_count
);

    typedef enum logic {
        ARB    = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      rr_ptr_q, rr_ptr_d;
    logic [1:0]                      win_q, win_d;
    logic                            we_q, we_d;
    logic                            locked_q, locked_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
    logic [2:0]                      gnt_q, gnt_d;
    logic [2:0]                      rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;
    logic                            mem_wen_q, mem_wen_d;
    logic                            busy_q, busy_d;
    logic [2:0][CNT_WIDTH-1:0]       cnt_q, cnt_d;

    // Winner selection signals
    logic                            found;
    logic [1:0]                      win;
    logic [1:0]                      cand1, cand2;
    logic                            sel_we;
    logic [ADDR_WIDTH-1:0]           sel_addr;
    logic [DATA_WIDTH-1:0]           sel_wdata;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Round-robin search from rr_ptr; lock0 restricts the search to requester 0.
    always_comb begin
        cand1 = inc3(rr_ptr_q);
        cand2 = inc3(cand1);
        found = 1'b0;
        win   = rr_ptr_q;
        if (lock0) begin
            found = req[0];
            win   = 2'd0;
        end else if (req[rr_ptr_q]) begin
            found = 1'b1;
            win   = rr_ptr_q;
        end else if (req[cand1]) begin
            found = 1'b1;
            win   = cand1;
        end else if (req[cand2]) begin
            found = 1'b1;
            win   = cand2;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (win == 2'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic. gnt/busy/mem_wen are registered on the ARB->ACCESS
    // edge so they are high exactly during ACCESS; the memory address/data
    // registers only load on a new grant, so they hold while idle.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        we_d      = we_q;
        locked_d  = locked_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = 3'b000;
        rvalid_d  = 3'b000;
        rdata_d   = rdata_q;
        mem_wen_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    state_d   = ACCESS;
                    win_d     = win;
                    we_d      = sel_we;
                    locked_d  = lock0;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    gnt_d     = 3'b001 << win;
                    mem_wen_d = sel_we;
                    busy_d    = 1'b1;
                end
            end
            ACCESS: begin
                state_d  = ARB;
                rvalid_d = gnt_q;
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                for (int i = 0; i < 3; i++) begin
                    if (win_q == 2'(i)) begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
                // Locked loader grants leave the round-robin position alone.
                if (!locked_q) begin
                    rr_ptr_d = inc3(win_q);
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Asynchronous reset clears mem_wen at once, aborting an in-flight write
    // and suppressing its rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB;
            rr_ptr_q  <= 2'd0;
            win_q     <= 2'd0;
            we_q      <= 1'b0;
            locked_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_q     <= 3'b000;
            rvalid_q  <= 3'b000;
            rdata_q   <= '0;
            mem_wen_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            we_q      <= we_d;
            locked_q  <= locked_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            mem_wen_q <= mem_wen_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign mem_raddr   = addr_q;
    assign mem_waddr   = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wen     = mem_wen_q;
    assign busy        = busy_q;
    assign grant_count = cnt_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter with a behavioural main_memory and
// a response scoreboard: each request pushes its expected response, and a
// monitor pops and compares on every rvalid pulse.
module tb_main_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic              clk;
    logic              rst;
    logic [2:0]        req;
    logic [2:0]        we;
    logic [3*AW-1:0]   addr;
    logic [3*DW-1:0]   wdata;
    logic              lock0;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_raddr;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wen;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic [3*CW-1:0]   grant_count;

    main_memory_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .lock0      (lock0),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .grant_count(grant_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main_memory model ----------------
    logic [DW-1:0] mem [0:255];
    assign mem_rdata = mem[mem_raddr[7:0]];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr[7:0]] = mem_wdata;
    end

    // ---------------- scoreboard ----------------
    // entry = {requester[1:0], is_read, data}
    logic [DW+2:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [DW+2:0] e;
        if (rst && rvalid != 3'b000) begin
            vec_cnt++;
            assert (exp_q.size() > 0) else begin
                err_cnt++;
                $error("FAIL rvalid_unexpected: observed rvalid=%b expected no response", rvalid);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_rvalid_id", 64'(rvalid), 64'(3'b001 << e[DW+2:DW+1]));
                if (e[DW]) chk("sb_rdata", 64'(rdata), 64'(e[DW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic push_read(input int i, input logic [DW-1:0] d);
        exp_q.push_back({2'(i), 1'b1, d});
    endtask

    task automatic push_write(input int i);
        exp_q.push_back({2'(i), 1'b0, {DW{1'b0}}});
    endtask

    function automatic logic [CW-1:0] gc(input int i);
        return grant_count[i*CW +: CW];
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst   = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        lock0 = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h01] = 32'h1111_1111;
        mem[8'h02] = 32'h2222_2222;
        mem[8'h03] = 32'h3333_3333;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h30] = 32'h3030_3030;
        mem[8'h40] = 32'h4040_4040;

        // Reset state
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mem_raddr", 64'(mem_raddr), 64'd0);
        chk("rst_grant_count", 64'(grant_count), 64'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Single read by requester 2
        set_fields(2, 1'b0, 32'h10, 32'h0);
        req = 3'b100;
        push_read(2, 32'hDEAD_BEEF);
        step();
        chk("t1_gnt", 64'(gnt), 64'b100);
        chk("t1_mem_raddr", 64'(mem_raddr), 64'h10);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_mem_wen", 64'(mem_wen), 64'd0);
        step();
        chk("t1_rvalid", 64'(rvalid), 64'b100);
        chk("t1_rdata", 64'(rdata), 64'hDEAD_BEEF);
        chk("t1_gc2", 64'(gc(2)), 64'd1);
        chk("t1_idle_gnt", 64'(gnt), 64'd0);
        chk("t1_idle_raddr_hold", 64'(mem_raddr), 64'h10);
        req = 3'b000;
        step();

        // Write by requester 1, then read back by requester 2
        set_fields(1, 1'b1, 32'h20, 32'h5);
        req = 3'b010;
        push_write(1);
        step();
        chk("t2_gnt", 64'(gnt), 64'b010);
        chk("t2_mem_wen", 64'(mem_wen), 64'd1);
        chk("t2_mem_waddr", 64'(mem_waddr), 64'h20);
        chk("t2_mem_wdata", 64'(mem_wdata), 64'h5);
        req = 3'b000;
        step();
        chk("t2_wen_one_cycle", 64'(mem_wen), 64'd0);
        chk("t2_rvalid", 64'(rvalid), 64'b010);
        step();
        chk("t2_wen_idle", 64'(mem_wen), 64'd0);
        set_fields(2, 1'b0, 32'h20, 32'h0);
        req = 3'b100;
        push_read(2, 32'h5);
        step();
        chk("t2_rd_gnt", 64'(gnt), 64'b100);
        req = 3'b000;
        step();
        chk("t2_readback", 64'(rdata), 64'h5);
        step();

        // Reset during the ACCESS cycle of a write
        set_fields(1, 1'b1, 32'h50, 32'h77);
        req = 3'b010;
        step();
        chk("t3_wen_before", 64'(mem_wen), 64'd1);
        req = 3'b000;
        #2;
        rst = 1'b0;
        #1;
        chk("t3_wen_async_drop", 64'(mem_wen), 64'd0);
        chk("t3_busy_async", 64'(busy), 64'd0);
        step();
        chk("t3_no_rvalid", 64'(rvalid), 64'd0);
        chk("t3_counters_zero", 64'(grant_count), 64'd0);
        chk("t3_mem_not_written", 64'(mem[8'h50]), 64'd0);
        #3;
        rst = 1'b1;
        step();
        chk("t3_state_arb", 64'(busy), 64'd0);

        // All three requesting: order 0,1,2,0,1,2, one grant per two cycles
        set_fields(0, 1'b0, 32'h01, 32'h0);
        set_fields(1, 1'b0, 32'h02, 32'h0);
        set_fields(2, 1'b0, 32'h03, 32'h0);
        for (int r = 0; r < 2; r++) begin
            push_read(0, 32'h1111_1111);
            push_read(1, 32'h2222_2222);
            push_read(2, 32'h3333_3333);
        end
        req = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t4_gnt_seq", 64'(gnt), (k % 2 == 1) ? 64'(3'b001 << (((k - 1) / 2) % 3)) : 64'd0);
        end
        req = 3'b000;
        chk("t4_gc0", 64'(gc(0)), 64'd2);
        chk("t4_gc1", 64'(gc(1)), 64'd2);
        chk("t4_gc2", 64'(gc(2)), 64'd2);
        step();

        // Move rr_ptr to 2 with a requester-1 read
        req = 3'b010;
        push_read(1, 32'h2222_2222);
        step();
        chk("t5_pre_gnt", 64'(gnt), 64'b010);
        req = 3'b000;
        step();

        // Lock: only requester 0 is served, rr_ptr stays at 2
        lock0 = 1'b1;
        req   = 3'b111;
        push_read(0, 32'h1111_1111);
        push_read(0, 32'h1111_1111);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t5_lock_gnt", 64'(gnt), (k % 2 == 1) ? 64'b001 : 64'd0);
        end
        req = 3'b110;
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("t5_lock_idle_gnt", 64'(gnt), 64'd0);
            chk("t5_lock_idle_busy", 64'(busy), 64'd0);
        end
        lock0 = 1'b0;
        push_read(2, 32'h3333_3333);
        step();
        chk("t5_unlock_gnt2", 64'(gnt), 64'b100);
        req = 3'b000;
        step();
        step();

        // Address changed after capture is ignored
        set_fields(1, 1'b0, 32'h30, 32'h0);
        req = 3'b010;
        push_read(1, 32'h3030_3030);
        step();
        chk("t6_mem_raddr", 64'(mem_raddr), 64'h30);
        set_fields(1, 1'b0, 32'h40, 32'h0);
        req = 3'b000;
        #1;
        chk("t6_mem_raddr_held", 64'(mem_raddr), 64'h30);
        step();
        chk("t6_rdata", 64'(rdata), 64'h3030_3030);
        step();
        step();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
